vga_timing_recover: RTL and testbench
=====================================

// Module: vga_timing_recover
// PURPOSE
//  Sink-side counterpart of the 800x600@60 timing generator. Samples an incoming
//  hsync/vsync/hblnk/vblnk stream, locks to it and regenerates hcount/vcount,
//  data-enable and frame-start. Used where a stage sees only sync/blank wires.
// PARAMETERS
//  H_TOTAL      1056  pclk cycles per line
//  H_ACTIVE     800   visible pixels per line (hblnk starts here)
//  H_SYNC_START 840   hcount at which hsync rises
//  V_TOTAL      628   lines per frame
//  V_ACTIVE     600   visible lines per frame (vblnk starts here)
//  V_SYNC_START 601   vcount at which vsync rises (always at hcount 0)
//  LOCK_LINES   4     consecutive H_TOTAL-length lines required before V acquire
// PORTS
//  pclk        in   1   pixel clock, 40 MHz
//  rst_n       in   1   reset, asynchronous, active-low
//  hsync_in    in   1   horizontal sync, active high
//  vsync_in    in   1   vertical sync, active high
//  hblnk_in    in   1   horizontal blank, active high
//  vblnk_in    in   1   vertical blank, active high
//  hcount      out  12  recovered pixel index
//  vcount      out  12  recovered line index
//  de          out  1   lock & hcount<H_ACTIVE & vcount<V_ACTIVE
//  lock        out  1   timing locked
//  frame_start out  1   1-cycle pulse when hcount==0 && vcount==0 && lock
//  line_len    out  12  last measured hsync-rise-to-rise period
//  err_cnt     out  8   blank mismatch count (tied 0 without VGA_BLANK_CHECK_EN)
// BEHAVIOUR
//  - One clock, pclk; reset rst_n asynchronous, active-low. Reset clears all
//    outputs and counters to 0 and forces state SEARCH. Asserting rst_n low
//    mid-frame clears outputs immediately; re-acquisition restarts from SEARCH.
//  - Inputs are registered once. hs_rise = hsync_in & ~hsync_q, same for vs_rise.
//  - Latency 1 pclk: when hs_rise is sampled at cycle t, hcount==H_SYNC_START at t+1.
//  - hcount free-runs +1 and wraps H_TOTAL-1 -> 0; vcount +1 on hcount wrap and
//    wraps V_TOTAL-1 -> 0. hs_rise loads hcount=H_SYNC_START. vs_rise loads
//    vcount=V_SYNC_START and hcount=0. A simultaneous hs_rise takes the hcount load.
//  - line_len counter: +1 per cycle, saturates at 4095. On hs_rise, latched to the
//    line_len output, then restarts at 1.
//  - FSM (lock=1 only in LOCKED):
//    SEARCH: on first hs_rise -> H_ACQ, good=0.
//    H_ACQ : on each hs_rise: period==H_TOTAL ? good++ : good=0.
//            When good==LOCK_LINES -> V_ACQ.
//    V_ACQ : on vs_rise -> LOCKED. A bad period, or 2*V_TOTAL lines without
//            vs_rise -> SEARCH.
//    LOCKED: any of the following -> SEARCH, with lock=0 on the next cycle:
//            hs_rise with period!=H_TOTAL; running count>H_TOTAL (missing hsync);
//            vs_rise when the predicted vcount!=V_SYNC_START or hcount!=0.
//  - In LOCKED, counter loads on correct sync edges are no-ops (values already match).
// CONFIGURATION
//  VGA_BLANK_CHECK_EN defined: in LOCKED, each cycle compares registered
//    hblnk_in/vblnk_in with (hcount>=H_ACTIVE)/(vcount>=V_ACTIVE). A mismatch
//    increments err_cnt (saturating at 255) and forces SEARCH. err_cnt clears
//    only on reset.
//  VGA_BLANK_CHECK_EN undefined: blank inputs are ignored; err_cnt is tied to 0.
// STRUCTURE
//  - Package vga_pkg: 800x600 timing constants, the 2-bit state enum
//    (SEARCH, H_ACQ, V_ACQ, LOCKED) and a shared 12-bit count type.
//  - Sub-module vga_sync_edge: input registers plus rise detection for
//    hsync/vsync, instantiated once.
// TESTING
//  1. Clean 800x600 stream after reset -> lock=1 after 5 hs rises plus the first
//     vs rise. hcount/vcount then equal the source counters delayed 1 cycle.
//     frame_start period is 663168 cycles.
//  2. Locked; one line stretched to 1057 cycles -> lock=0 one cycle after that
//     hs rise, line_len=1057; re-lock on the next frame.
//  3. Locked; hsync held low -> lock=0 once the running count reaches 1057.
//  4. Locked; rst_n pulsed low at vcount 300 -> all outputs 0 immediately;
//     re-lock within 2 frames.
//  5. Locked; vsync rise moved to line 605 -> lock=0; vcount reloads 601 on that edge.
//  6. VGA_BLANK_CHECK_EN; hblnk_in forced 0 at hcount 900 while locked ->
//     err_cnt=1, lock=0. Without the macro: lock stays 1, err_cnt=0.

Source files
------------

// File: rtl/vga_timing_recover_pkg.sv
// Shared 800x600@60 timing constants, recovery FSM states and count type.
package vga_pkg;

    typedef logic [11:0] count_t;

    typedef enum logic [1:0] {
        SEARCH,
        H_ACQ,
        V_ACQ,
        LOCKED
    } state_t;

    localparam int unsigned VGA_H_TOTAL      = 1056;
    localparam int unsigned VGA_H_ACTIVE     = 800;
    localparam int unsigned VGA_H_SYNC_START = 840;
    localparam int unsigned VGA_V_TOTAL      = 628;
    localparam int unsigned VGA_V_ACTIVE     = 600;
    localparam int unsigned VGA_V_SYNC_START = 601;
    localparam int unsigned VGA_LOCK_LINES   = 4;

endpackage

// File: rtl/vga_timing_recover_if.sv
// Sync/blank stream into the recovery block and the regenerated timing out of it.
interface vga_timing_recover_if;
    import vga_pkg::*;

    logic       hsync_in;
    logic       vsync_in;
    logic       hblnk_in;
    logic       vblnk_in;
    count_t     hcount;
    count_t     vcount;
    logic       de;
    logic       lock;
    logic       frame_start;
    count_t     line_len;
    logic [7:0] err_cnt;

    modport master (
        output hsync_in, vsync_in, hblnk_in, vblnk_in,
        input  hcount, vcount, de, lock, frame_start, line_len, err_cnt
    );

    modport slave (
        input  hsync_in, vsync_in, hblnk_in, vblnk_in,
        output hcount, vcount, de, lock, frame_start, line_len, err_cnt
    );

endinterface

// File: rtl/vga_timing_recover_sync_edge.sv
// Registers the incoming sync/blank wires and flags hsync/vsync rising edges.
module vga_sync_edge (
    input  logic pclk,
    input  logic rst_n,
    input  logic hsync_in,
    input  logic vsync_in,
    input  logic hblnk_in,
    input  logic vblnk_in,
    output logic hs_rise,
    output logic vs_rise,
    output logic hblnk_q,
    output logic vblnk_q
);
    logic hsync_q;
    logic vsync_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            hblnk_q <= 1'b0;
            vblnk_q <= 1'b0;
        end else begin
            hsync_q <= hsync_in;
            vsync_q <= vsync_in;
            hblnk_q <= hblnk_in;
            vblnk_q <= vblnk_in;
        end
    end

    assign hs_rise = hsync_in & ~hsync_q;
    assign vs_rise = vsync_in & ~vsync_q;

endmodule

// File: rtl/vga_timing_recover.sv
// Locks to an 800x600 sync/blank stream and regenerates hcount/vcount, de, frame_start.
// Define VGA_BLANK_CHECK_EN to cross-check blank inputs while locked (err_cnt).
module vga_timing_recover
    import vga_pkg::*;
#(
    parameter int unsigned H_TOTAL      = VGA_H_TOTAL,
    parameter int unsigned H_ACTIVE     = VGA_H_ACTIVE,
    parameter int unsigned H_SYNC_START = VGA_H_SYNC_START,
    parameter int unsigned V_TOTAL      = VGA_V_TOTAL,
    parameter int unsigned V_ACTIVE     = VGA_V_ACTIVE,
    parameter int unsigned V_SYNC_START = VGA_V_SYNC_START,
    parameter int unsigned LOCK_LINES   = VGA_LOCK_LINES
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    vga_timing_recover_if.slave  bus
);
    localparam count_t HT       = count_t'(H_TOTAL);
    localparam count_t HT_M1    = count_t'(H_TOTAL - 1);
    localparam count_t HA       = count_t'(H_ACTIVE);
    localparam count_t HSS      = count_t'(H_SYNC_START);
    localparam count_t VT_M1    = count_t'(V_TOTAL - 1);
    localparam count_t VA       = count_t'(V_ACTIVE);
    localparam count_t VSS      = count_t'(V_SYNC_START);
    localparam count_t LL       = count_t'(LOCK_LINES);
    localparam count_t VACQ_MAX = count_t'(2 * V_TOTAL);

    logic   hs_rise, vs_rise, hblnk_q, vblnk_q;
    state_t state;
    logic   lock;
    count_t hcount, vcount, period, line_len, good, vacq_lines;
    count_t hc_free, vc_free;
    logic   h_wrap, bad_period, missing_hs, vs_misplaced, blank_err;

    vga_sync_edge u_edge (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .hsync_in (bus.hsync_in),
        .vsync_in (bus.vsync_in),
        .hblnk_in (bus.hblnk_in),
        .vblnk_in (bus.vblnk_in),
        .hs_rise  (hs_rise),
        .vs_rise  (vs_rise),
        .hblnk_q  (hblnk_q),
        .vblnk_q  (vblnk_q)
    );

    // Free-running prediction; a correctly placed vsync must land on it exactly.
    always_comb begin
        h_wrap       = (hcount == HT_M1);
        hc_free      = h_wrap ? '0 : hcount + 1'b1;
        vc_free      = vcount;
        if (h_wrap)
            vc_free = (vcount == VT_M1) ? '0 : vcount + 1'b1;
        bad_period   = hs_rise && (period != HT);
        missing_hs   = !hs_rise && (period > HT);
        vs_misplaced = vs_rise && ((vc_free != VSS) || (hc_free != '0));
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount   <= '0;
            vcount   <= '0;
            period   <= '0;
            line_len <= '0;
        end else begin
            hcount <= hc_free;
            vcount <= vc_free;
            if (vs_rise) begin
                vcount <= VSS;
                hcount <= '0;
            end
            if (hs_rise) begin
                hcount   <= HSS;
                line_len <= period;
                period   <= count_t'(1);
            end else if (period != '1) begin
                period <= period + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEARCH;
            lock       <= 1'b0;
            good       <= '0;
            vacq_lines <= '0;
        end else begin
            unique case (state)
                SEARCH: begin
                    lock <= 1'b0;
                    if (hs_rise) begin
                        state <= H_ACQ;
                        good  <= '0;
                    end
                end
                H_ACQ: begin
                    if (hs_rise) begin
                        if (bad_period) begin
                            good <= '0;
                        end else if (good + 1'b1 == LL) begin
                            state      <= V_ACQ;
                            vacq_lines <= '0;
                        end else begin
                            good <= good + 1'b1;
                        end
                    end
                end
                V_ACQ: begin
                    if (bad_period || (vacq_lines == VACQ_MAX)) begin
                        state <= SEARCH;
                    end else if (vs_rise) begin
                        state <= LOCKED;
                        lock  <= 1'b1;
                    end else if (hs_rise) begin
                        vacq_lines <= vacq_lines + 1'b1;
                    end
                end
                LOCKED: begin
                    if (bad_period || missing_hs || vs_misplaced || blank_err) begin
                        state <= SEARCH;
                        lock  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef VGA_BLANK_CHECK_EN
    logic [7:0] err_cnt;

    // Registered blanks line up with the current hcount/vcount (both one cycle behind source).
    assign blank_err = (hblnk_q != (hcount >= HA)) || (vblnk_q != (vcount >= VA));

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if ((state == LOCKED) && blank_err && (err_cnt != '1))
            err_cnt <= err_cnt + 1'b1;
    end

    assign bus.err_cnt = err_cnt;
`else
    logic blank_unused;

    assign blank_unused = hblnk_q ^ vblnk_q;
    assign blank_err    = 1'b0;
    assign bus.err_cnt  = '0;
`endif

    assign bus.hcount      = hcount;
    assign bus.vcount      = vcount;
    assign bus.line_len    = line_len;
    assign bus.lock        = lock;
    assign bus.de          = lock && (hcount < HA) && (vcount < VA);
    assign bus.frame_start = lock && (hcount == '0) && (vcount == '0);

endmodule

// File: tb/tb_vga_timing_recover.sv
// Directed bench for vga_timing_recover on a shrunken 20x12 raster.
module tb_vga_timing_recover;

    localparam int HT  = 20;
    localparam int HA  = 12;
    localparam int HSS = 14;
    localparam int VT  = 12;
    localparam int VA  = 8;
    localparam int VSS = 9;

    logic pclk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int   src_h = HT - 1;
    int   src_v = VT - 1;
    bit   stretch = 0;
    bit   hs_kill = 0;
    bit   vs_late = 0;
    bit   blk_force = 0;

    vga_timing_recover_if vif ();

    vga_timing_recover #(
        .H_TOTAL      (HT),
        .H_ACTIVE     (HA),
        .H_SYNC_START (HSS),
        .V_TOTAL      (VT),
        .V_ACTIVE     (VA),
        .V_SYNC_START (VSS),
        .LOCK_LINES   (4)
    ) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        vif.hsync_in = !hs_kill && (src_h >= HSS) && (src_h < HSS + 3);
        vif.vsync_in = vs_late ? (src_v == VSS + 2) : ((src_v >= VSS) && (src_v < VSS + 2));
        vif.hblnk_in = (src_h >= HA) && !(blk_force && (src_h == HA + 6));
        vif.vblnk_in = (src_v >= VA);
    endtask

    // Source advances on negedge; after cyc() returns the DUT has sampled (src_h, src_v).
    task automatic cyc();
        @(negedge pclk);
        if (stretch && (src_h == HA)) begin
            stretch = 0;
        end else if (src_h == HT - 1) begin
            src_h = 0;
            src_v = (src_v == VT - 1) ? 0 : src_v + 1;
        end else begin
            src_h++;
        end
        drive();
        @(posedge pclk);
        #1;
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!((src_h == h) && (src_v == v)) && (n < 2000)) begin
            cyc();
            n++;
        end
        chk("run_to_reached", 32'((src_h == h) && (src_v == v)), 32'd1);
    endtask

    initial begin
        int n;
        drive();
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_hcount", vif.hcount, 0);
        chk("rst_vcount", vif.vcount, 0);
        chk("rst_lock", vif.lock, 0);
        chk("rst_de", vif.de, 0);
        chk("rst_frame_start", vif.frame_start, 0);
        chk("rst_line_len", vif.line_len, 0);
        chk("rst_err_cnt", vif.err_cnt, 0);
        rst_n = 1'b1;

        // Clean stream: 5 hs rises then the vs rise at line 9 gives lock.
        run_to(HT - 1, VSS - 1);
        chk("t1_prelock", vif.lock, 0);
        cyc();
        chk("t1_lock", vif.lock, 1);
        chk("t1_hcount", vif.hcount, 0);
        chk("t1_vcount", vif.vcount, VSS);
        chk("t1_line_len", vif.line_len, HT);
        run_to(HT - 1, VT - 1);
        chk("t1_fs_before", vif.frame_start, 0);
        cyc();
        chk("t1_fs_pulse", vif.frame_start, 1);
        chk("t1_de_origin", vif.de, 1);
        cyc();
        chk("t1_fs_after", vif.frame_start, 0);
        n = 1;
        while (!vif.frame_start && (n < 1000)) begin
            cyc();
            n++;
        end
        chk("t1_fs_period", n, HT * VT);
        for (int i = 0; i < HT * VT; i++) begin
            cyc();
            chk("t1_track_h", vif.hcount, src_h);
            chk("t1_track_v", vif.vcount, src_v);
            chk("t1_track_de", vif.de, (src_h < HA) && (src_v < VA));
        end

        // One line stretched by a cycle inside horizontal blank.
        run_to(0, 1);
        stretch = 1;
        run_to(HSS - 1, 1);
        chk("t2_lock_before", vif.lock, 1);
        cyc();
        chk("t2_lock_lost", vif.lock, 0);
        chk("t2_line_len", vif.line_len, HT + 1);
        chk("t2_hcount_load", vif.hcount, HSS);
        chk("t2_vcount", vif.vcount, 1);
        run_to(HT - 1, VSS - 1);
        chk("t2_relock_pre", vif.lock, 0);
        cyc();
        chk("t2_relock", vif.lock, 1);

        // Hsync held low: lost once the running count passes a line.
        run_to(HSS + 3, 1);
        hs_kill = 1;
        run_to(HSS, 2);
        chk("t3_lock_at_count_full", vif.lock, 1);
        cyc();
        chk("t3_lock_lost", vif.lock, 0);
        chk("t3_line_len", vif.line_len, HT);
        run_to(HSS + 3, 2);
        hs_kill = 0;
        run_to(HT - 1, VSS - 1);
        chk("t3_relock_pre", vif.lock, 0);
        cyc();
        chk("t3_relock", vif.lock, 1);

        // Asynchronous reset mid-frame.
        run_to(5, 4);
        chk("t4_de_before", vif.de, 1);
        rst_n = 1'b0;
        #1;
        chk("t4_hcount", vif.hcount, 0);
        chk("t4_vcount", vif.vcount, 0);
        chk("t4_lock", vif.lock, 0);
        chk("t4_de", vif.de, 0);
        chk("t4_line_len", vif.line_len, 0);
        repeat (3) cyc();
        rst_n = 1'b1;
        run_to(HT - 1, VSS - 1);
        chk("t4_relock_pre", vif.lock, 0);
        cyc();
        chk("t4_relock", vif.lock, 1);

        // Vsync rise moved two lines late.
        run_to(0, 1);
        vs_late = 1;
        run_to(HT - 1, VSS + 1);
        chk("t5_lock_before", vif.lock, 1);
        cyc();
        chk("t5_lock_lost", vif.lock, 0);
        chk("t5_vcount_load", vif.vcount, VSS);
        chk("t5_hcount_load", vif.hcount, 0);
        vs_late = 0;
        run_to(HT - 1, VSS - 1);
        chk("t5_relock_pre", vif.lock, 0);
        cyc();
        chk("t5_relock", vif.lock, 1);
        chk("t5_relock_vcount", vif.vcount, VSS);

        // Hblank dropped for one cycle in the middle of horizontal blank.
        run_to(HA + 5, 2);
        blk_force = 1;
        cyc();
        chk("t6_lock_at_glitch", vif.lock, 1);
        cyc();
        blk_force = 0;
`ifdef VGA_BLANK_CHECK_EN
        chk("t6_lock", vif.lock, 0);
        chk("t6_err_cnt", vif.err_cnt, 1);
`else
        chk("t6_lock", vif.lock, 1);
        chk("t6_err_cnt", vif.err_cnt, 0);
`endif
        chk("t6_hcount", vif.hcount, HA + 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
